// File: rtl/array_stream_reader_if.sv
// Bundle of the capture-writer port, the burst command and the valid/ready
// sample stream of array_stream_reader.
//   master : drives writes, start command and out_ready; observes stream/status
//   slave  : the reader engine itself
interface array_stream_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   len;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              start_err;
  logic [7:0]        beat_count;

  modport master (
    output wr_en, wr_addr, wr_data, start, start_addr, len, out_ready,
    input  out_valid, out_data, out_last, busy, done, start_err, beat_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, start_addr, len, out_ready,
    output out_valid, out_data, out_last, busy, done, start_err, beat_count
  );
endinterface

// File: rtl/array_stream_reader.sv
// Read-side engine for the 16-entry sample array. Holds the storage array,
// accepts one write per cycle from the capture writer, and on start streams
// len samples from start_addr (wrapping) over a valid/ready interface.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : array_stream_reader_if.slave (write port, burst command,
//                sample stream, busy/done/start_err status, beat_count)
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | loading/presenting samples until the last one is accepted
// DONE   | one-cycle completion pulse, then back to IDLE
module array_stream_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  array_stream_reader_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   remaining;
  logic              out_valid;
  logic              out_last;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic              start_err;
  logic [7:0]        beat_count;
  logic              accept;
  logic              load;

  assign accept = out_valid && bus.out_ready;
  // A new sample may enter the output register when it is empty or being drained.
  assign load   = (state == STREAM) && (remaining != '0) && (!out_valid || bus.out_ready);

  // Storage is not reset; a same-cycle write is seen by the output load only
  // on the following cycle, so a colliding load returns the old contents.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      remaining  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_err  <= 1'b0;
      beat_count <= '0;
    end else begin
      done      <= 1'b0;
      start_err <= 1'b0;
      if (accept) beat_count <= beat_count + 8'd1;

      case (state)
        IDLE: begin
          if (bus.start) begin
            rd_ptr    <= bus.start_addr;
            remaining <= bus.len;
            busy      <= 1'b1;
            if (bus.len != '0) begin
              state <= STREAM;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        STREAM: begin
          if (bus.start) start_err <= 1'b1;
          if (accept && out_last) begin
            state     <= DONE;
            done      <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (load) begin
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
            out_last  <= (remaining == 1);
            rd_ptr    <= rd_ptr + 1'b1;
            remaining <= remaining - 1'b1;
          end else if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end

        DONE: begin
          if (bus.start) start_err <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_last   = out_last;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.start_err  = start_err;
  assign bus.beat_count = beat_count;
endmodule

// File: tb/tb_array_stream_reader.sv
// Bench for array_stream_reader: directed and randomized bursts checked
// against an array/queue reference model.
module tb_array_stream_reader;
  logic clk;
  logic rst_n;

  array_stream_reader_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  array_stream_reader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_pass   = 0;
  logic [7:0] ref_mem [16];
  int        exp_beats = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    ref_mem[a]  = d;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0 repeating
  task automatic burst(input logic [3:0] sa, input logic [4:0] ln, input int mode,
                       input bit poke, input bit collide);
    logic [7:0] q[$];
    logic [7:0] e;
    logic [7:0] held_d;
    logic       held_l;
    logic [3:0] cw_addr;
    logic [7:0] cw_data;
    bit held = 0;
    bit fin  = 0;
    bit cw   = 0;
    bit r;
    int cyc  = 0;
    int got  = 0;
    int nxt;
    int err_p = 0;

    for (int i = 0; i < int'(ln); i++) q.push_back(ref_mem[(int'(sa) + i) % 16]);
    bus.start      = 1'b1;
    bus.start_addr = sa;
    bus.len        = ln;
    bus.out_ready  = 1'b1;
    @(negedge clk);

    while (!fin && cyc <= 80) begin
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (bus.start_err) err_p++;
      if (cyc == 0) chk("busy_after_start", bus.busy, 1);
      if (cyc == 0 && ln != 0) chk("no_valid_at_start_edge", bus.out_valid, 0);
      if (cyc == 1 && ln != 0) chk("first_valid_latency", bus.out_valid, 1);
      if (bus.done) begin
        chk("done_beats", got, ln);
        chk("done_valid_low", bus.out_valid, 0);
        chk("done_busy", bus.busy, 1);
        if (mode == 0) chk("done_cycle", cyc, (ln == 0) ? 0 : int'(ln) + 1);
        fin = 1;
      end else begin
        if (held) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_data", bus.out_data, held_d);
          chk("hold_last", bus.out_last, held_l);
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = 1'($urandom % 2);
          default: r = (cyc % 3 == 0);
        endcase
        bus.out_ready = r;
        if (poke && cyc == 2) begin
          bus.start      = 1'b1;
          bus.start_addr = 4'd9;
          bus.len        = 5'd3;
        end
        nxt = got + (bus.out_valid ? 1 : 0);
        if (collide && !cw && cyc >= 3 && nxt < int'(ln) && (!bus.out_valid || r)) begin
          cw_addr     = 4'((int'(sa) + nxt) % 16);
          cw_data     = ~ref_mem[cw_addr];
          bus.wr_en   = 1'b1;
          bus.wr_addr = cw_addr;
          bus.wr_data = cw_data;
          cw          = 1;
        end
        if (bus.out_valid && r) begin
          e = (q.size() > 0) ? q.pop_front() : 8'hxx;
          chk("beat_data", bus.out_data, e);
          chk("beat_last", bus.out_last, (q.size() == 0) ? 1 : 0);
          got++;
          exp_beats = (exp_beats + 1) % 256;
        end
        held   = bus.out_valid && !r;
        held_d = bus.out_data;
        held_l = bus.out_last;
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    if (!fin) chk("burst_timeout", 0, 1);
    if (collide) begin
      chk("collision_write_made", cw, 1);
      if (cw) ref_mem[cw_addr] = cw_data;
    end
    chk("start_err_pulses", err_p, poke ? 1 : 0);
    chk("beat_count", bus.beat_count, exp_beats);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_drop", bus.busy, 0);
    chk("start_err_idle", bus.start_err, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.len        = '0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_start_err", bus.start_err, 0);
    chk("rst_beats", bus.beat_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 16; a++) wr(4'(a), 8'(a + 8'h10));

    burst(4'd0, 5'd4, 0, 0, 0);   // 10,11,12,13
    burst(4'd14, 5'd4, 0, 0, 0);  // wrap 1E,1F,10,11
    burst(4'd2, 5'd3, 2, 0, 0);   // stalled consumer
    burst(4'd5, 5'd0, 0, 0, 0);   // empty burst
    burst(4'd8, 5'd8, 0, 1, 1);   // start while busy + write collision
    burst(4'd11, 5'd16, 0, 0, 0); // full wrap
    burst(4'd0, 5'd2, 0, 0, 0);   // original data still 10,11

    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w < 3; w++) wr(4'($urandom_range(0, 15)), 8'($urandom));
      burst(4'($urandom_range(0, 15)), 5'($urandom_range(1, 16)), 1, 0, 0);
    end

    // reset in the middle of a burst
    bus.start      = 1'b1;
    bus.start_addr = 4'd0;
    bus.len        = 5'd8;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    exp_beats = (exp_beats + 2) % 256;
    chk("pre_reset_beats", bus.beat_count, exp_beats);
    chk("pre_reset_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_last", bus.out_last, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_beats", bus.beat_count, 0);
    exp_beats = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_busy", bus.busy, 0);
    burst(4'd0, 5'd2, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
